intan_cache: RTL
================

INTAN_CACHE -- requirements
Module: intan_cache

Interface
REQ-001 Parameter LANES, default 2: number of 8-bit byte lanes; sample width is 8*LANES.
REQ-002 Parameter DEPTH, default 64: entries per lane FIFO; SHALL be a power of 2, minimum 4.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 dev_kind  input  2  frame size select: 00 none, 01 16 samples, 10 32 samples, 11 64 samples.
REQ-006 fs_read  input  1  frame-start request, level, held high until fd_read is seen.
REQ-007 fd_read  output  1  frame-done acknowledge.
REQ-008 smp_vld  input  1  input sample strobe, one sample per cycle.
REQ-009 smp_data  input  8*LANES  input sample; lane i takes bits [8i+7:8i].
REQ-010 rxen  input  LANES  per-lane read enable.
REQ-011 rxd  output  8*LANES  per-lane read data; lane i on bits [8i+7:8i].
REQ-012 empty  output  LANES  per-lane empty flag.
REQ-013 err  output  1  sticky error flag.

Function
REQ-014 FSM states: IDLE, FILL, DONE.
REQ-015 IDLE->FILL when fs_read=1 and dev_kind!=00; frame count N latched from dev_kind on this transition; sample counter cleared.
REQ-016 IDLE with fs_read=1 and dev_kind=00 -> DONE directly, err set.
REQ-017 In FILL each cycle with smp_vld=1 increments the sample counter by 1, whether or not the sample is stored.
REQ-018 FILL->DONE on the cycle the counter reaches N; fd_read=1 from the next cycle.
REQ-019 DONE holds fd_read=1 until fs_read=0; DONE->IDLE on the first cycle fs_read=0; fd_read=0 in IDLE and FILL.
REQ-020 smp_vld outside FILL is ignored; no write, no count, no error.
REQ-021 A sample is written to all lanes in the same cycle only if no lane is full at that cycle; a read in the same cycle does not free space for that write.
REQ-022 A sample arriving in FILL with any lane full is dropped in all lanes and sets err.
REQ-023 Each lane reads independently; rxen[i]=1 with empty[i]=0 pops one entry of lane i.
REQ-024 rxen[i]=1 with empty[i]=1 is ignored; rxd lane i holds its value; err unaffected.
REQ-025 Pointers wrap modulo DEPTH; full/empty use an extra pointer MSB, so exactly DEPTH entries are storable.
REQ-026 empty[i] updates the cycle after the write or pop that changes it.
REQ-027 err is sticky; it is cleared only on the IDLE->FILL transition or by reset.
REQ-028 dev_kind changes during FILL or DONE have no effect on the current frame.

Reset
REQ-029 While rst=0, the FSM is in IDLE, counters and pointers are 0, fd_read=0, err=0, empty all 1, and rxd all 0.
REQ-030 A reset during FILL aborts the frame; stored data is discarded.
REQ-031 The first clock edge after rst=1 behaves as in IDLE.

Configuration
REQ-032 The macro INTAN_CACHE_FWFT_EN selects the read mode.
REQ-033 With INTAN_CACHE_FWFT_EN defined, rxd lane i presents the head entry whenever empty[i]=0, and a pop advances it on the next cycle.
REQ-034 Without the macro, rxd lane i is registered and updates one cycle after a valid pop; otherwise it holds.

Verification
REQ-035 dev_kind=01, fs_read=1, 16 samples 0x0100..0x010F -> fd_read=1 the cycle after the 16th; lane1 pops 0x01 x16; lane0 pops 0x00..0x0F; err=0.
REQ-036 DEPTH=4, dev_kind=01, 6 samples with no reads -> 4 stored, samples 5 and 6 dropped, err=1, counter continues; fd_read after the 16th sample.
REQ-037 dev_kind=00, fs_read=1 -> fd_read=1 two cycles later, err=1, nothing stored; fs_read=0 -> IDLE; next valid frame start clears err.
REQ-038 Pop lane0 only for 3 cycles after 4 writes -> empty=2'b10 pattern absent; lane0 shows 1 entry left, lane1 shows 4; rxen on empty lane ignored.
REQ-039 rst=0 asserted mid-FILL after 5 samples -> empty all 1, fd_read=0, err=0 immediately; after release, a new frame completes normally.
REQ-040 Pointer wrap: DEPTH=4, 10 interleaved write/pop pairs -> data read back in order, no err, empty=all 1 at end.

Source files
------------

// File: rtl/intan_cache_if.sv
// Bus interface for intan_cache: frame handshake, sample input and
// per-lane read port. The testbench (master) drives requests, samples and
// read enables; the cache (slave) returns acknowledge, read data, flags.
interface intan_cache_if #(
  parameter int LANES = 2
);
  logic [1:0]         dev_kind;
  logic               fs_read;
  logic               fd_read;
  logic               smp_vld;
  logic [8*LANES-1:0] smp_data;
  logic [LANES-1:0]   rxen;
  logic [8*LANES-1:0] rxd;
  logic [LANES-1:0]   empty;
  logic               err;

  modport master (
    output dev_kind, fs_read, smp_vld, smp_data, rxen,
    input  fd_read, rxd, empty, err
  );

  modport slave (
    input  dev_kind, fs_read, smp_vld, smp_data, rxen,
    output fd_read, rxd, empty, err
  );
endinterface

// File: rtl/intan_cache.sv
// intan_cache: frame-based sample capture into LANES parallel byte FIFOs.
// A frame of 16/32/64 samples is requested with fs_read and acknowledged
// with fd_read. Each sample is written to every lane at once (only if no
// lane is full); lanes are drained independently.
// Optional feature: define INTAN_CACHE_FWFT_EN for first-word-fall-through
// read data; the default build uses registered read data updated on a pop.
module intan_cache #(
  parameter int LANES = 2,
  parameter int DEPTH = 64
) (
  input logic         clk,
  input logic         rst,
  intan_cache_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_FILL = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Frame length decoded from the device kind; 00 means no frame.
  function automatic logic [6:0] frame_size(input logic [1:0] kind);
    logic [6:0] n;
    case (kind)
      2'b01:   n = 7'd16;
      2'b10:   n = 7'd32;
      2'b11:   n = 7'd64;
      default: n = 7'd0;
    endcase
    return n;
  endfunction

  logic [1:0]       state_r, state_s;
  logic [6:0]       cnt_r, cnt_s, cnt_inc_s;
  logic [6:0]       frame_n_r, frame_n_s;
  logic             fd_read_r, fd_read_s;
  logic             err_r, err_s;
  logic             wr_en_s;
  logic             any_full_s;
  logic [AW:0]      wr_ptr_r, wr_ptr_s;
  logic [AW:0]      rd_ptr_r [LANES];
  logic [AW:0]      rd_ptr_s [LANES];
  logic [LANES-1:0] full_s;
  logic [LANES-1:0] pop_s;
  logic [LANES-1:0] empty_r, empty_s;
  logic [7:0]       rxd_r [LANES];
  logic [7:0]       rxd_s [LANES];
  logic [7:0]       mem_r [LANES][DEPTH];

  // Per-lane full detection: same slot index, opposite wrap bit.
  always_comb begin
    full_s = '0;
    for (int i = 0; i < LANES; i++) begin
      full_s[i] = (wr_ptr_r[AW] != rd_ptr_r[i][AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[i][AW-1:0]);
    end
    any_full_s = |full_s;
  end

  // Frame FSM: sample counting, write gating, acknowledge and error flag.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    frame_n_s = frame_n_r;
    fd_read_s = 1'b0;
    err_s     = err_r;
    wr_en_s   = 1'b0;
    cnt_inc_s = cnt_r + 7'd1;
    case (state_r)
      ST_IDLE: begin
        if (bus.fs_read) begin
          if (bus.dev_kind != 2'b00) begin
            state_s   = ST_FILL;
            frame_n_s = frame_size(bus.dev_kind);
            cnt_s     = 7'd0;
            err_s     = 1'b0;
          end else begin
            state_s = ST_DONE;
            err_s   = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (bus.smp_vld) begin
          cnt_s = cnt_inc_s;
          // A full lane blocks the sample in every lane; it still counts.
          if (any_full_s) begin
            err_s = 1'b1;
          end else begin
            wr_en_s = 1'b1;
          end
          if (cnt_inc_s == frame_n_r) begin
            state_s   = ST_DONE;
            fd_read_s = 1'b1;
          end else begin
            state_s = ST_FILL;
          end
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_DONE: begin
        if (bus.fs_read) begin
          state_s   = ST_DONE;
          fd_read_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Pointer advance, next empty flags and next read data per lane.
  always_comb begin
    if (wr_en_s) begin
      wr_ptr_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_s = wr_ptr_r;
    end
    for (int i = 0; i < LANES; i++) begin
      pop_s[i] = bus.rxen[i] && !empty_r[i];
      if (pop_s[i]) begin
        rd_ptr_s[i] = rd_ptr_r[i] + PTR_ONE;
      end else begin
        rd_ptr_s[i] = rd_ptr_r[i];
      end
      empty_s[i] = (wr_ptr_s == rd_ptr_s[i]);
`ifdef INTAN_CACHE_FWFT_EN
      // Present the next head; bypass the memory when it is written now.
      if (wr_en_s && (wr_ptr_r[AW-1:0] == rd_ptr_s[i][AW-1:0])) begin
        rxd_s[i] = bus.smp_data[8*i +: 8];
      end else begin
        rxd_s[i] = mem_r[i][rd_ptr_s[i][AW-1:0]];
      end
`else
      if (pop_s[i]) begin
        rxd_s[i] = mem_r[i][rd_ptr_r[i][AW-1:0]];
      end else begin
        rxd_s[i] = rxd_r[i];
      end
`endif
    end
  end

  // Control and status registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 7'd0;
      frame_n_r <= 7'd0;
      fd_read_r <= 1'b0;
      err_r     <= 1'b0;
      wr_ptr_r  <= '0;
      empty_r   <= '1;
      for (int i = 0; i < LANES; i++) begin
        rd_ptr_r[i] <= '0;
        rxd_r[i]    <= 8'h00;
      end
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      frame_n_r <= frame_n_s;
      fd_read_r <= fd_read_s;
      err_r     <= err_s;
      wr_ptr_r  <= wr_ptr_s;
      empty_r   <= empty_s;
      for (int i = 0; i < LANES; i++) begin
        rd_ptr_r[i] <= rd_ptr_s[i];
        rxd_r[i]    <= rxd_s[i];
      end
    end
  end

  // Sample storage; contents are meaningless once pointers are reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < LANES; i++) begin
        mem_r[i][wr_ptr_r[AW-1:0]] <= bus.smp_data[8*i +: 8];
      end
    end
  end

  assign bus.fd_read = fd_read_r;
  assign bus.err     = err_r;
  assign bus.empty   = empty_r;

  for (genvar g = 0; g < LANES; g++) begin : g_rxd
    assign bus.rxd[8*g +: 8] = rxd_r[g];
  end

endmodule
